// File: rtl/rl_stage_sequencer.sv
// Round sequencer: starts each unmasked stage in order and grants it the shared memory port.
// Optional per-stage watchdog is enabled by defining SEQ_WATCHDOG_EN.
module rl_stage_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned WDT_CYCLES = 1023,
  localparam int unsigned IdxW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         round_start,
  input  logic [NUM_STAGES-1:0]        skip_mask,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES-1:0]        stage_wr_en,
  input  logic [NUM_STAGES*WORD_W-1:0] stage_wdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wr_en,
  output logic [WORD_W-1:0]            mem_wdata,
  output logic [IdxW-1:0]              cur_stage,
  output logic                         busy,
  output logic                         round_done,
  output logic                         timeout_err
);

  typedef enum logic [2:0] {StIdle, StScan, StLaunch, StWait, StFinish} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [IdxW-1:0]       scan_idx;
  logic                  scan_found;
  logic                  granted;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);
  logic [WdtW-1:0] wdt_q, wdt_d;
  logic            timeout_q, timeout_d;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      mask_q    <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
`ifdef SEQ_WATCHDOG_EN
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Lowest unmasked stage at or above the current index.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = idx_q;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (i >= int'(idx_q) && !mask_q[i]) begin
        scan_found = 1'b1;
        scan_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
`ifdef SEQ_WATCHDOG_EN
    wdt_d     = wdt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (en && round_start) begin
          mask_d  = skip_mask;
          idx_d   = '0;
          state_d = StScan;
`ifdef SEQ_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StScan: begin
        if (scan_found) begin
          idx_d   = scan_idx;
          state_d = StLaunch;
        end else begin
          state_d = StFinish;
        end
      end
      StLaunch: begin
        state_d = StWait;
`ifdef SEQ_WATCHDOG_EN
        wdt_d = '0;
`endif
      end
      StWait: begin
        if (stage_done[idx_q]) begin
          if (idx_q == IdxW'(NUM_STAGES - 1)) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wdt_q == WdtW'(WDT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          if (idx_q == IdxW'(NUM_STAGES - 1)) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end else begin
          wdt_d = wdt_q + 1'b1;
        end
`endif
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Dropping en aborts the round from any active state.
    if (!en && state_q != StIdle) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    granted     = (state_q == StLaunch) || (state_q == StWait);
    stage_start = '0;
    if (state_q == StLaunch && en) begin
      stage_start[idx_q] = 1'b1;
    end
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wr_en  = 1'b0;
    if (granted) begin
      mem_addr  = stage_addr[int'(idx_q)*ADDR_W +: ADDR_W];
      mem_wdata = stage_wdata[int'(idx_q)*WORD_W +: WORD_W];
      mem_wr_en = stage_wr_en[idx_q] && en;
    end
    cur_stage  = idx_q;
    busy       = (state_q != StIdle);
    round_done = (state_q == StFinish) && en;
`ifdef SEQ_WATCHDOG_EN
    timeout_err = timeout_q;
`else
    timeout_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rl_stage_sequencer.sv
// Directed bench for rl_stage_sequencer; exercises SEQ_WATCHDOG_EN paths when that macro is set.
module tb_rl_stage_sequencer;

  logic        clock = 1'b0;
  logic        rst, en, round_start;
  logic [3:0]  skip_mask, stage_start, stage_done, stage_wr_en;
  logic [43:0] stage_addr;
  logic [63:0] stage_wdata;
  logic [10:0] mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [1:0]  cur_stage;
  logic        busy, round_done, timeout_err;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int sc[4] = '{0, 0, 0, 0};

  rl_stage_sequencer #(
    .NUM_STAGES(4), .ADDR_W(11), .WORD_W(16), .WDT_CYCLES(8)
  ) dut (
    .clock(clock), .rst(rst), .en(en), .round_start(round_start), .skip_mask(skip_mask),
    .stage_start(stage_start), .stage_done(stage_done), .stage_addr(stage_addr),
    .stage_wr_en(stage_wr_en), .stage_wdata(stage_wdata), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .cur_stage(cur_stage), .busy(busy),
    .round_done(round_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (round_done) rd_cnt++;
    for (int i = 0; i < 4; i++) if (stage_start[i]) sc[i]++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the LAUNCH cycle of stage i; the stage answers done 3 cycles after its start.
  task automatic do_stage(input int i);
    logic [3:0] onehot;
    onehot = 4'b0001 << i;
    chk("start_onehot", 32'(stage_start), 32'(onehot));
    chk("cur_stage", 32'(cur_stage), 32'(i));
    tick();
    chk("start_width", 32'(stage_start), 32'h0);
    tick();
    tick();
    stage_done = onehot;
    tick();
    stage_done = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; round_start = 1'b0; skip_mask = '0; stage_done = '0;
    stage_addr = '0; stage_wr_en = '0; stage_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_start", 32'(stage_start), 32'h0);
    chk("rst_cur", 32'(cur_stage), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(round_done), 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);

    // T1: full round, no skips
    en = 1'b1; skip_mask = 4'b0000; round_start = 1'b1;
    tick();
    round_start = 1'b0; skip_mask = 4'b1111;
    chk("t1_busy", 32'(busy), 32'h1);
    tick();
    do_stage(0); tick();
    do_stage(1); tick();
    do_stage(2); tick();
    do_stage(3);
    chk("t1_round_done", 32'(round_done), 32'h1);
    tick();
    chk("t1_done_width", 32'(round_done), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'h1);
    for (int i = 0; i < 4; i++) chk("t1_start_cnt", 32'(sc[i]), 32'h1);

    // T2/T3: mask 0101, mux checks while waiting on stage 1
    skip_mask = 4'b0101; round_start = 1'b1;
    tick();
    round_start = 1'b0; skip_mask = 4'b0000;
    tick();
    chk("t2_start1", 32'(stage_start), 32'h2);
    chk("t2_cur1", 32'(cur_stage), 32'h1);
    tick();
    stage_addr[11 +: 11] = 11'h274; stage_addr[22 +: 11] = 11'h7ff;
    stage_wdata[16 +: 16] = 16'hbeef; stage_wr_en = 4'b0100;
    #1;
    chk("t3_addr", 32'(mem_addr), 32'h274);
    chk("t3_wr_other", 32'(mem_wr_en), 32'h0);
    chk("t3_wdata", 32'(mem_wdata), 32'hbeef);
    stage_wr_en = 4'b0110;
    #1;
    chk("t3_wr_own", 32'(mem_wr_en), 32'h1);
    stage_done = 4'b1100;
    tick();
    chk("t2_foreign_done", 32'(mem_addr), 32'h274);
    chk("t2_still_cur1", 32'(cur_stage), 32'h1);
    stage_done = 4'b0010;
    tick();
    stage_done = '0;
    chk("t2_scan_addr", 32'(mem_addr), 32'h0);
    chk("t2_scan_wr", 32'(mem_wr_en), 32'h0);
    stage_wr_en = '0;
    tick();
    do_stage(3);
    chk("t2_round_done", 32'(round_done), 32'h1);
    tick();
    chk("t2_cnt0", 32'(sc[0]), 32'h1);
    chk("t2_cnt1", 32'(sc[1]), 32'h2);
    chk("t2_cnt2", 32'(sc[2]), 32'h1);
    chk("t2_cnt3", 32'(sc[3]), 32'h2);

    // All stages masked: round_done two cycles after round_start
    skip_mask = 4'b1111; round_start = 1'b1;
    tick();
    round_start = 1'b0;
    chk("all_scan_done", 32'(round_done), 32'h0);
    tick();
    chk("all_finish", 32'(round_done), 32'h1);
    tick();
    chk("all_idle", 32'(busy), 32'h0);
    chk("all_rd_cnt", 32'(rd_cnt), 32'h3);

    // T4: drop en while waiting on stage 2
    skip_mask = 4'b0000; round_start = 1'b1;
    tick();
    round_start = 1'b0;
    tick();
    do_stage(0); tick();
    do_stage(1); tick();
    chk("t4_cur2", 32'(cur_stage), 32'h2);
    tick();
    stage_wr_en = 4'b0100;
    #1;
    chk("t4_wr_granted", 32'(mem_wr_en), 32'h1);
    en = 1'b0;
    #1;
    chk("t4_wr_forced", 32'(mem_wr_en), 32'h0);
    tick();
    chk("t4_idle", 32'(busy), 32'h0);
    en = 1'b1; stage_wr_en = '0;
    tick();
    chk("t4_no_round_done", 32'(rd_cnt), 32'h3);

    // New round restarts at stage 0; a done during LAUNCH is ignored
    stage_addr[0 +: 11] = 11'h155; round_start = 1'b1;
    tick();
    round_start = 1'b0;
    tick();
    chk("t4_restart0", 32'(stage_start), 32'h1);
    stage_done = 4'b0001;
    tick();
    stage_done = '0;
    chk("early_done_ignored", 32'(mem_addr), 32'h155);
    tick();
    stage_done = 4'b0001;
    tick();
    stage_done = '0;
    tick();
    do_stage(1); tick();
    tick();

    // T5: reset while waiting on stage 2
    stage_wr_en = 4'b0100; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_start", 32'(stage_start), 32'h0);
    chk("t5_cur", 32'(cur_stage), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(round_done), 32'h0);
    chk("t5_tmo", 32'(timeout_err), 32'h0);
    chk("t5_wr", 32'(mem_wr_en), 32'h0);
    stage_wr_en = '0;

`ifdef SEQ_WATCHDOG_EN
    // T6: stage 0 never answers
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
    tick();
    repeat (8) tick();
    chk("t6_before_tmo", 32'(timeout_err), 32'h0);
    chk("t6_still_cur0", 32'(cur_stage), 32'h0);
    tick();
    chk("t6_tmo_set", 32'(timeout_err), 32'h1);
    tick();
    do_stage(1); tick();
    do_stage(2); tick();
    do_stage(3);
    chk("t6_round_done", 32'(round_done), 32'h1);
    tick();
    chk("t6_tmo_sticky", 32'(timeout_err), 32'h1);
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
    chk("t6_tmo_cleared", 32'(timeout_err), 32'h0);
`else
    // Without the watchdog a silent stage holds WAIT indefinitely
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
    tick();
    repeat (20) tick();
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_cur0", 32'(cur_stage), 32'h0);
    chk("hold_tmo", 32'(timeout_err), 32'h0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
